// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: widths, FSM states and the
// round-robin pointer helper. Supports up to four requesters.
package alu_pkg;

   localparam int ALU_W     = 16;
   localparam int ALU_CMD_W = 3;
   localparam int IDX_W     = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Pointer to the requester after idx, wrapping at nreq.
   function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                                input int nreq);
      if (int'(idx) >= nreq - 1) begin
         return '0;
      end
      return idx + IDX_W'(1);
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after rr,
// wrapping, reported as one-hot and as an index.
module rr_pick
   import alu_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] rr,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic found;

   // Scan priority distances 0..NREQ-1 from rr; the first requester hit wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int off = 0; off < NREQ; off++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!found && req[k] && (((k - int'(rr) + NREQ) % NREQ) == off)) begin
               found      = 1'b1;
               gnt[k]     = 1'b1;
               gnt_idx    = IDX_W'(k);
            end
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU among NREQ
// requesters. Optional grant hold via `lock` when ALU_ARB_LOCK_EN is defined.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int W    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req,
`ifdef ALU_ARB_LOCK_EN
   input  logic [NREQ-1:0]           lock,
`endif
   input  logic [NREQ*W-1:0]         op_a,
   input  logic [NREQ*W-1:0]         op_b,
   input  logic [NREQ*ALU_CMD_W-1:0] op_cmd,
   output logic [NREQ-1:0]           done,
   output logic [W-1:0]              res,
   output logic                      res_cy,
   output logic                      res_z,
   output logic                      alu_cs,
   output logic [W-1:0]              alu_a,
   output logic [W-1:0]              alu_b,
   output logic [ALU_CMD_W-1:0]      alu_cmd,
   input  logic [W-1:0]              alu_r,
   input  logic                      alu_cy,
   input  logic                      alu_z
);

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       rr_q, rr_d;
   logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
   logic [NREQ-1:0]        gnt_oh_q, gnt_oh_d;
   logic [NREQ-1:0]        done_q, done_d;
   logic [W-1:0]           res_q, res_d;
   logic                   res_cy_q, res_cy_d;
   logic                   res_z_q, res_z_d;
   logic                   alu_cs_q, alu_cs_d;
   logic [W-1:0]           alu_a_q, alu_a_d;
   logic [W-1:0]           alu_b_q, alu_b_d;
   logic [ALU_CMD_W-1:0]   alu_cmd_q, alu_cmd_d;

   logic [NREQ-1:0]        pick_oh;
   logic [IDX_W-1:0]       pick_idx;
   logic [W-1:0]           sel_a, sel_b;
   logic [ALU_CMD_W-1:0]   sel_cmd;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req     (req),
      .rr      (rr_q),
      .gnt     (pick_oh),
      .gnt_idx (pick_idx)
   );

   // One-hot mux of the winner's operands and command.
   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_cmd = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (pick_oh[k]) begin
            sel_a   = op_a[k*W +: W];
            sel_b   = op_b[k*W +: W];
            sel_cmd = op_cmd[k*ALU_CMD_W +: ALU_CMD_W];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      gnt_idx_d = gnt_idx_q;
      gnt_oh_d  = gnt_oh_q;
      done_d    = '0;
      res_d     = res_q;
      res_cy_d  = res_cy_q;
      res_z_d   = res_z_q;
      alu_cs_d  = alu_cs_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_cmd_d = alu_cmd_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               alu_a_d   = sel_a;
               alu_b_d   = sel_b;
               alu_cmd_d = sel_cmd;
               alu_cs_d  = 1'b1;
               gnt_idx_d = pick_idx;
               gnt_oh_d  = pick_oh;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            res_d    = alu_r;
            res_cy_d = alu_cy;
            res_z_d  = alu_z;
            done_d   = gnt_oh_q;
            alu_cs_d = 1'b0;
            state_d  = DONE;
         end
         DONE: begin
            rr_d = rr_next(gnt_idx_q, NREQ);
`ifdef ALU_ARB_LOCK_EN
            // A locking requester that still requests keeps the next slot.
            if (|(lock & req & gnt_oh_q)) begin
               rr_d = gnt_idx_q;
            end
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_q      <= '0;
         gnt_idx_q <= '0;
         gnt_oh_q  <= '0;
         done_q    <= '0;
         res_q     <= '0;
         res_cy_q  <= 1'b0;
         res_z_q   <= 1'b0;
         alu_cs_q  <= 1'b0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_cmd_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         gnt_idx_q <= gnt_idx_d;
         gnt_oh_q  <= gnt_oh_d;
         done_q    <= done_d;
         res_q     <= res_d;
         res_cy_q  <= res_cy_d;
         res_z_q   <= res_z_d;
         alu_cs_q  <= alu_cs_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_cmd_q <= alu_cmd_d;
      end
   end

   assign done    = done_q;
   assign res     = res_q;
   assign res_cy  = res_cy_q;
   assign res_z   = res_z_q;
   assign alu_cs  = alu_cs_q;
   assign alu_a   = alu_a_q;
   assign alu_b   = alu_b_q;
   assign alu_cmd = alu_cmd_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with an adder standing in for the ALU.
// Define ALU_ARB_LOCK_EN to also exercise the grant-hold feature.
module tb_alu_arbiter;

   localparam int NREQ = 2;
   localparam int W    = 16;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b1;
   logic [NREQ-1:0]   req;
`ifdef ALU_ARB_LOCK_EN
   logic [NREQ-1:0]   lock;
`endif
   logic [NREQ*W-1:0] op_a, op_b;
   logic [NREQ*3-1:0] op_cmd;
   logic [NREQ-1:0]   done;
   logic [W-1:0]      res, alu_a, alu_b, alu_r;
   logic              res_cy, res_z, alu_cs, alu_cy, alu_z;
   logic [2:0]        alu_cmd;
   logic [W:0]        alu_sum;

   // ALU stub: r = a + b, cy = carry-out, z = (r == 0)
   assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
   assign alu_r   = alu_sum[W-1:0];
   assign alu_cy  = alu_sum[W];
   assign alu_z   = (alu_sum[W-1:0] == '0);

   always #5 clk = ~clk;

   alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
`ifdef ALU_ARB_LOCK_EN
      .lock    (lock),
`endif
      .op_a    (op_a),
      .op_b    (op_b),
      .op_cmd  (op_cmd),
      .done    (done),
      .res     (res),
      .res_cy  (res_cy),
      .res_z   (res_z),
      .alu_cs  (alu_cs),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_cmd (alu_cmd),
      .alu_r   (alu_r),
      .alu_cy  (alu_cy),
      .alu_z   (alu_z)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit bit_at(input logic [NREQ-1:0] v, input int k);
      logic [NREQ-1:0] t;
      t = v >> k;
      return t[0];
   endfunction

   // Transaction-level model: an accepted request occupies the ALU for three
   // cycles; its operands appear one edge later, its result one edge after that.
   int              m_cycle, m_free, m_done_edge, m_rr_edge, m_rr, m_w, mk;
   bit              m_valid = 1'b0;
   logic [NREQ-1:0] e_done;
   logic [W-1:0]    e_res, e_a, e_b;
   logic            e_cy, e_z, e_cs;
   logic [2:0]      e_cmd;
   logic [W:0]      m_sum;
   logic [NREQ*W-1:0] m_ta;
   logic [NREQ*3-1:0] m_tc;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_valid = 1'b1;
         m_cycle = 0; m_free = 0; m_done_edge = -1; m_rr_edge = -1; m_rr = 0; m_w = 0;
         e_done = '0; e_res = '0; e_cy = 1'b0; e_z = 1'b0;
         e_cs = 1'b0; e_a = '0; e_b = '0; e_cmd = '0;
      end else begin
         e_done = '0;
         if (m_cycle == m_done_edge) begin
            m_sum  = {1'b0, e_a} + {1'b0, e_b};
            e_res  = m_sum[W-1:0];
            e_cy   = m_sum[W];
            e_z    = (m_sum[W-1:0] == '0);
            e_done = NREQ'(1) << m_w;
            e_cs   = 1'b0;
            m_rr_edge = m_cycle + 1;
         end else if (m_cycle == m_rr_edge) begin
            m_rr = (m_w + 1) % NREQ;
`ifdef ALU_ARB_LOCK_EN
            if (bit_at(lock, m_w) && bit_at(req, m_w)) m_rr = m_w;
`endif
         end else if (m_cycle >= m_free && req != '0) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
               mk = (m_rr + i) % NREQ;
               if (bit_at(req, mk)) m_w = mk;
            end
            m_ta  = op_a >> (m_w * W);
            e_a   = m_ta[W-1:0];
            m_ta  = op_b >> (m_w * W);
            e_b   = m_ta[W-1:0];
            m_tc  = op_cmd >> (m_w * 3);
            e_cmd = m_tc[2:0];
            e_cs  = 1'b1;
            m_done_edge = m_cycle + 1;
            m_free      = m_cycle + 3;
         end
         m_cycle++;
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         chk("cyc_done",    32'(done),    32'(e_done));
         chk("cyc_res",     32'(res),     32'(e_res));
         chk("cyc_res_cy",  32'(res_cy),  32'(e_cy));
         chk("cyc_res_z",   32'(res_z),   32'(e_z));
         chk("cyc_alu_cs",  32'(alu_cs),  32'(e_cs));
         chk("cyc_alu_a",   32'(alu_a),   32'(e_a));
         chk("cyc_alu_b",   32'(alu_b),   32'(e_b));
         chk("cyc_alu_cmd", 32'(alu_cmd), 32'(e_cmd));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected to end earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic wait_done(input string name, output int idx, output int cyc);
      idx = -1;
      cyc = 0;
      for (int c = 1; c <= 12 && idx < 0; c++) begin
         @(negedge clk);
         if (done != '0) begin
            cyc = c;
            for (int k = 0; k < NREQ; k++) if (bit_at(done, k)) idx = k;
         end
      end
      if (idx < 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: got no done within 12 cycles, expected a done pulse", name);
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int        idx, cyc;
   int        ord01[4]  = '{0, 1, 0, 1};
`ifdef ALU_ARB_LOCK_EN
   int        ordlk[4]  = '{0, 1, 1, 0};
`endif

   initial begin
      req = '0; op_a = '0; op_b = '0; op_cmd = '0;
`ifdef ALU_ARB_LOCK_EN
      lock = '0;
`endif
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_done",   32'(done),   32'h0);
      chk("rst_res",    32'(res),    32'h0);
      chk("rst_alu_cs", 32'(alu_cs), 32'h0);
      chk("rst_alu_a",  32'(alu_a),  32'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_alu_cs", 32'(alu_cs), 32'h0);
      chk("idle_done",   32'(done),   32'h0);

      // Single op from requester 0
      op_a[15:0] = 16'hFF00; op_b[15:0] = 16'hF0F0; op_cmd[2:0] = 3'b000; req[0] = 1'b1;
      @(negedge clk);
      chk("t2_cs",  32'(alu_cs), 32'h1);
      chk("t2_a",   32'(alu_a),  32'hFF00);
      wait_done("t2_wait", idx, cyc);
      chk("t2_idx", 32'(idx),     32'h0);
      chk("t2_lat", 32'(cyc + 1), 32'd2);
      chk("t2_res", 32'(res),     32'hEFF0);
      chk("t2_cy",  32'(res_cy),  32'h1);
      chk("t2_z",   32'(res_z),   32'h0);
      chk("t2_cs0", 32'(alu_cs),  32'h0);
      req[0] = 1'b0;
      @(negedge clk);

      // Single op from requester 1, zero result
      op_a[31:16] = 16'h0001; op_b[31:16] = 16'hFFFF; op_cmd[5:3] = 3'b101; req[1] = 1'b1;
      wait_done("t3_wait", idx, cyc);
      chk("t3_idx", 32'(idx),    32'h1);
      chk("t3_lat", 32'(cyc),    32'd2);
      chk("t3_res", 32'(res),    32'h0000);
      chk("t3_cy",  32'(res_cy), 32'h1);
      chk("t3_z",   32'(res_z),  32'h1);
      req[1] = 1'b0;
      repeat (4) @(negedge clk);
      chk("t3_hold_res", 32'(res),     32'h0000);
      chk("t3_hold_z",   32'(res_z),   32'h1);
      chk("t3_hold_a",   32'(alu_a),   32'h0001);
      chk("t3_hold_cmd", 32'(alu_cmd), 32'h5);

      // Both requesters held from reset: strict alternation, one op per 3 cycles
      pulse_reset();
      op_a[15:0]  = 16'h1234; op_b[15:0]  = 16'h1111; op_cmd[2:0] = 3'b010;
      op_a[31:16] = 16'h8000; op_b[31:16] = 16'h8000; op_cmd[5:3] = 3'b111;
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_done("t4_wait", idx, cyc);
         chk("t4_order", 32'(idx), 32'(ord01[i]));
         chk("t4_gap",   32'(cyc), (i == 0) ? 32'd2 : 32'd3);
         chk("t4_res",   32'(res), (ord01[i] == 0) ? 32'h2345 : 32'h0000);
         if (i == 3) req = '0;
      end
      @(negedge clk);

      // Reset during EXEC discards the op; the held request restarts from rr=0
      req[0] = 1'b1;
      wait_done("t5_pre", idx, cyc);
      req[0] = 1'b0;
      @(negedge clk);
      req = 2'b11;
      @(negedge clk);
      chk("t5_cs",  32'(alu_cs), 32'h1);
      chk("t5_win", 32'(alu_a),  32'h8000);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_arst_done", 32'(done),    32'h0);
      chk("t5_arst_res",  32'(res),     32'h0);
      chk("t5_arst_cy",   32'(res_cy),  32'h0);
      chk("t5_arst_z",    32'(res_z),   32'h0);
      chk("t5_arst_cs",   32'(alu_cs),  32'h0);
      chk("t5_arst_a",    32'(alu_a),   32'h0);
      chk("t5_arst_b",    32'(alu_b),   32'h0);
      chk("t5_arst_cmd",  32'(alu_cmd), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_done("t5_wait", idx, cyc);
      chk("t5_idx", 32'(idx), 32'h0);
      chk("t5_lat", 32'(cyc), 32'd2);
      chk("t5_res", 32'(res), 32'h2345);
      req = '0;
      @(negedge clk);

`ifdef ALU_ARB_LOCK_EN
      // Requester 1 keeps the ALU while it holds lock
      pulse_reset();
      lock = 2'b10;
      req  = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_done("t6_wait", idx, cyc);
         chk("t6_order", 32'(idx), 32'(ordlk[i]));
         chk("t6_res",   32'(res), (ordlk[i] == 0) ? 32'h2345 : 32'h0000);
         if (i == 2) lock = '0;
         if (i == 3) req = '0;
      end
      @(negedge clk);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single 16-bit combinational `alu` between up to four requesters (e.g. fetch/address unit, execute unit, debug port). Each requester raises a request with operands and a 3-bit command. The arbiter registers the winning request onto the ALU port and captures `r`/`cy`/`z` one cycle later. It then returns them with a one-cycle `done` pulse to that requester. It sits between the requesting units and the `alu` instance and is the only driver of the ALU's `cs`, `a`, `b` and `cmd`.

## Interface
- `NREQ`, 2: number of requesters, 2..4
- `W`, 16: operand/result width; must match `alu`
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  NREQ  per-requester request level
- `lock`  in  NREQ  per-requester grant-hold request (only with `ALU_ARB_LOCK_EN`)
- `op_a`  in  NREQ*W  operand a, requester i at [i*W +: W]
- `op_b`  in  NREQ*W  operand b, same packing
- `op_cmd`  in  NREQ*3  ALU command, requester i at [i*3 +: 3]
- `done`  out  NREQ  one-cycle completion pulse, one-hot or zero
- `res`  out  W  captured ALU result
- `res_cy`  out  1  captured carry
- `res_z`  out  1  captured zero flag
- `alu_cs`  out  1  to `alu.cs`
- `alu_a`  out  W  to `alu.a`
- `alu_b`  out  W  to `alu.b`
- `alu_cmd`  out  3  to `alu.cmd`
- `alu_r`  in  W  from `alu.r`
- `alu_cy`  in  1  from `alu.cy`
- `alu_z`  in  1  from `alu.z`

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: if any `req` is set, pick the winner by round-robin starting at pointer `rr`, lowest index first from `rr` upward with wrap. On the edge: latch the winner's operands and cmd into `alu_a/alu_b/alu_cmd`, set `alu_cs`=1, store the grant index, go to EXEC. If no `req` is set, stay in IDLE.
- EXEC: the ALU settles combinationally. On the edge: capture `alu_r/alu_cy/alu_z` into `res/res_cy/res_z`, set `done[grant]`=1, set `alu_cs`=0, go to DONE.
- DONE: `done[grant]` is high for exactly this cycle. On the edge: clear `done`, set `rr` = grant+1 (wrapping modulo NREQ), go to IDLE.
- Requester rules: hold `req`, operands and cmd stable from raising `req` until it sees `done`. Drop `req` in the `done` cycle unless it wants another operation.
- `res/res_cy/res_z` hold their value until the next capture.
- `alu_a/alu_b/alu_cmd` hold their last value when `alu_cs`=0.
- `cmd` is passed through opaquely. The arbiter never decodes it.
- A `req` that falls during EXEC does not abort the operation. The result is still delivered.
- Reset value of every output is 0: `done`, `res`, `res_cy`, `res_z`, `alu_cs`, `alu_a`, `alu_b`, `alu_cmd`. Internal `rr`=0, state=IDLE.
- Reset asserted mid-operation discards the in-flight operation. No `done` is issued.

## Timing
- Latency: `req` sampled at edge E0 → `alu_cs` high after E0 → `done` and `res` valid after E1 → back in IDLE after E2.
- Throughput: one operation per 3 cycles. This holds for back-to-back requests from the same or different requesters.
- Fairness: with all requesters active continuously, grants rotate 0,1,…,NREQ-1,0. The worst-case wait is NREQ operations.
- Simultaneous new `req` and `done` for the same requester: the new request is arbitrated in the following IDLE like any other.

## Configuration
- `ALU_ARB_LOCK_EN` defined: the `lock` port exists. If `lock[grant]` and `req[grant]` are both high in DONE, `rr` is set to `grant` instead of grant+1, so that requester wins the next IDLE. This supports multi-word sequences such as 32-bit add in two halves.
- Not defined: the `lock` port is absent and rotation is always grant+1.

## Structure
- Shared package `alu_pkg`: `ALU_W`=16, `ALU_CMD_W`=3, the FSM state enum (IDLE/EXEC/DONE) and the index width for `NREQ`≤4.
- One sub-module, `rr_pick`: combinational round-robin priority picker. Inputs are `req` and `rr`. Outputs are a one-hot grant and the grant index.

## Test plan
The bench stubs the ALU as r=a+b, cy=carry-out, z=(r==0).

- Reset then idle, no `req` → all outputs 0, `alu_cs`=0 indefinitely.
- req[0] with a=16'hFF00, b=16'hF0F0, cmd=3'b000 → `alu_cs` high for 1 cycle. `done[0]` pulses 2 cycles after `req`, with res=16'hEFF0, cy=1, z=0.
- req[1] with a=16'h0001, b=16'hFFFF → done[1] with res=16'h0000, cy=1, z=1. `res` holds until the next op.
- req[0] and req[1] raised on the same cycle and held, from reset → grants in order 0,1,0,1, with `done` pulses every 3 cycles.
- `rst_n` low during EXEC → outputs 0 immediately (asynchronous). No `done`. After release, the held `req` is re-served from rr=0.
- `ALU_ARB_LOCK_EN`: lock[1]=1 and req[0], req[1] both held → requester 1 granted consecutively until lock[1] drops, then requester 0.
